// File: rtl/aurora_tx_arbiter.sv
// aurora_tx_arbiter: packet-level round-robin arbiter sharing one Aurora TX AXI4-Stream
module aurora_tx_arbiter #(
  parameter int NUM_SRC = 2
) (
  input  logic                  user_clk,
  input  logic                  ur_ch_reset,
  input  logic                  channel_up,
  input  logic [0:32*NUM_SRC-1] s_axis_tdata,
  input  logic [0:4*NUM_SRC-1]  s_axis_tkeep,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  input  logic [NUM_SRC-1:0]    s_axis_tlast,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  output logic [0:31]           m_axis_tdata,
  output logic [0:3]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [NUM_SRC-1:0]    grant,
  output logic [15:0]           flush_count
);
  localparam int IW = $clog2(NUM_SRC);
  localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, FLUSH = 2'd2;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, gidx_q, gidx_d, pick, gnext;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [0:31] data_q, data_d;
  logic [0:3] keep_q, keep_d;
  logic valid_q, valid_d, last_q, last_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic acc, acc_last;
  // ready never looks at any tvalid, only at registered state and the sink
  assign s_axis_tready = grant_q & {NUM_SRC{(state_q == XFER) ? (!valid_q || m_axis_tready) : (state_q == FLUSH)}};
  assign acc = |(s_axis_tready & s_axis_tvalid);
  assign acc_last = |(s_axis_tready & s_axis_tvalid & s_axis_tlast);
  assign gnext = (gidx_q == IW'(NUM_SRC - 1)) ? '0 : gidx_q + 1'b1;
  always_comb begin
    pick = rr_q;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (s_axis_tvalid[IW'((int'(rr_q) + k) % NUM_SRC)]) pick = IW'((int'(rr_q) + k) % NUM_SRC);
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    gidx_d = gidx_q;
    grant_d = grant_q;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    valid_d = valid_q && !m_axis_tready;
    fcnt_d = fcnt_q;
    if (state_q == IDLE && channel_up && |s_axis_tvalid) begin
      state_d = XFER;
      gidx_d = pick;
      grant_d = NUM_SRC'(1) << pick;
    end
    if (state_q == XFER && acc) begin
      data_d = s_axis_tdata[32*gidx_q +: 32];
      keep_d = s_axis_tkeep[4*gidx_q +: 4];
      last_d = acc_last;
      valid_d = 1'b1;
    end
    // a tlast taken in the same cycle as a drop still completes the packet
    if (acc_last) begin
      state_d = IDLE;
      rr_d = gnext;
      grant_d = '0;
      if (state_q == FLUSH) fcnt_d = (&fcnt_q) ? fcnt_q : fcnt_q + 16'd1;
    end else if (state_q == XFER && !channel_up) begin
      state_d = FLUSH;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge user_clk) begin
    if (ur_ch_reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      gidx_q <= '0;
      grant_q <= '0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gidx_q <= gidx_d;
      grant_q <= grant_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
      valid_q <= valid_d;
      fcnt_q <= fcnt_d;
    end
  end
  assign grant = grant_q;
  assign m_axis_tdata = data_q;
  assign m_axis_tkeep = keep_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast = last_q;
  assign flush_count = fcnt_q;
endmodule
